// File: rtl/daq_readout_pkg.sv
// Shared types and constants for the DDR readout controller.
// Contents: readout FSM state enum, beat size, AXI response/burst encodings, stream header magic.
package daq_readout_pkg;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDrain} readout_state_e;

  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned HDR_BYTES  = 8;

  localparam logic [1:0] AXI_OKAY       = 2'b00;
  localparam logic [2:0] AXI_SIZE_64B   = 3'b110;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [7:0] HDR_MAGIC0 = 8'hA5;
  localparam logic [7:0] HDR_MAGIC1 = 8'h5A;

endpackage

// File: rtl/ddr_readout_ctrl_if.sv
// AXI4 read-channel bundle (AR + R) between the readout master and the DDR slave port.
// Modports: master (readout controller), slave (memory side / bench model).
interface ddr_readout_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 512
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/readout_beat_fifo.sv
// Synchronous first-word-fall-through beat buffer with free-space count.
// Ports: clk_i, sys_rst_i (sync, active high), push_i/data_i write side,
//        pop_i/data_o read side (data_o valid whenever !empty_o), free_o free entries.
// Caller must not push when full or pop when empty.
module readout_beat_fifo #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 128
) (
  input  logic                           clk_i,
  input  logic                           sys_rst_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     free_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (sys_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign free_o  = CntW'(DEPTH) - count_q;
endmodule

// File: rtl/ddr_readout_ctrl.sv
// AXI4 read master draining captured samples from DDR into the SiTCP TX byte FIFO.
// Ports: clk, sys_rst (sync, active high); start/base_addr/beat_count/channel_ctrl command;
//        busy, done (1-cycle), rresp_err (sticky) status; axi read-channel master bundle;
//        tcp_txd/tcp_tx_wr byte stream, tcp_tx_full backpressure.
// Build option: READOUT_HEADER_EN prepends an 8-byte header (A5 5A ch 00 count[31:0] BE).
// AXI_DATA_W must equal 8*BEAT_BYTES; MAX_BURST a power of two <= 64; FIFO_DEPTH >= 2*MAX_BURST.
module ddr_readout_ctrl
  import daq_readout_pkg::*;
#(
  parameter int unsigned AXI_DATA_W = 512,
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned MAX_BURST  = 64,
  parameter int unsigned FIFO_DEPTH = 128
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic                      start,
  input  logic [31:0]               base_addr,
  input  logic [31:0]               beat_count,
  input  logic [7:0]                channel_ctrl,
  output logic                      busy,
  output logic                      done,
  output logic                      rresp_err,
  ddr_readout_ctrl_if.master        axi,
  output logic [7:0]                tcp_txd,
  output logic                      tcp_tx_wr,
  input  logic                      tcp_tx_full
);
`ifdef READOUT_HEADER_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  readout_state_e          state_q;
  logic [AXI_ADDR_W-1:0]   addr_q, araddr_q;
  logic [31:0]             remaining_q;
  logic [7:0]              arlen_q;
  logic                    arvalid_q, rready_q, busy_q, done_q, err_q;

  logic [AXI_DATA_W-1:0]   sh_q;
  logic [6:0]              bytes_left_q;
  logic [7:0]              txd_q;
  logic                    tx_wr_q;

  logic                    start_acc, beat_push, fifo_pop, fifo_empty;
  logic [AXI_DATA_W-1:0]   fifo_dout, hdr_beat;
  logic [CntW-1:0]         fifo_free;
  logic [31:0]             burst_len, to_bound;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = ^base_addr[5:0];
  assign start_acc = start && (state_q == StIdle);
  assign beat_push = axi.rvalid && rready_q;
  assign fifo_pop  = (bytes_left_q == '0) && !fifo_empty && !(start_acc && HdrEn);
  assign hdr_beat  = AXI_DATA_W'({beat_count[7:0], beat_count[15:8], beat_count[23:16],
                                  beat_count[31:24], 8'h00, channel_ctrl, HDR_MAGIC1, HDR_MAGIC0});

  // Burst length: min(remaining, MAX_BURST, beats left before the next 4 KB boundary).
  always_comb begin
    to_bound  = 32'd64 - {26'd0, addr_q[11:6]};
    burst_len = remaining_q;
    if (burst_len > MAX_BURST) burst_len = MAX_BURST;
    if (burst_len > to_bound)  burst_len = to_bound;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      araddr_q    <= '0;
      remaining_q <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (beat_push && (axi.rresp != AXI_OKAY)) err_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            err_q       <= 1'b0;
            addr_q      <= {base_addr[AXI_ADDR_W-1:6], 6'd0};
            remaining_q <= beat_count;
            if (beat_count != 32'd0) begin
              busy_q  <= 1'b1;
              state_q <= StAddr;
            end else if (HdrEn) begin
              // Header-only transfer: wait for the header bytes to leave.
              busy_q  <= 1'b1;
              state_q <= StDrain;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StAddr: begin
          if (!arvalid_q) begin
            // Only issue when a whole max burst fits, so rready can stay high in DATA.
            if (32'(fifo_free) >= MAX_BURST) begin
              arvalid_q   <= 1'b1;
              araddr_q    <= addr_q;
              arlen_q     <= 8'(burst_len - 32'd1);
              addr_q      <= addr_q + AXI_ADDR_W'(burst_len << 6);
              remaining_q <= remaining_q - burst_len;
            end
          end else if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StData;
          end
        end
        StData: begin
          if (beat_push && axi.rlast) begin
            rready_q <= 1'b0;
            state_q  <= (remaining_q == 32'd0) ? StDrain : StAddr;
          end
        end
        StDrain: begin
          if (fifo_empty && (bytes_left_q == '0)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Byte serializer: shifts the current beat (or header) out LSB byte first.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      sh_q         <= '0;
      bytes_left_q <= '0;
      txd_q        <= '0;
      tx_wr_q      <= 1'b0;
    end else begin
      tx_wr_q <= 1'b0;
      if (start_acc && HdrEn) begin
        sh_q         <= hdr_beat;
        bytes_left_q <= 7'(HDR_BYTES);
      end else if (bytes_left_q != '0) begin
        if (!tcp_tx_full) begin
          txd_q        <= sh_q[7:0];
          tx_wr_q      <= 1'b1;
          sh_q         <= sh_q >> 8;
          bytes_left_q <= bytes_left_q - 1'b1;
        end
      end else if (fifo_pop) begin
        sh_q         <= fifo_dout;
        bytes_left_q <= 7'(BEAT_BYTES);
      end
    end
  end

  readout_beat_fifo #(
    .WIDTH (AXI_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .sys_rst_i (sys_rst),
    .push_i    (beat_push),
    .data_i    (axi.rdata),
    .pop_i     (fifo_pop),
    .data_o    (fifo_dout),
    .empty_o   (fifo_empty),
    .free_o    (fifo_free)
  );

  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = AXI_SIZE_64B;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rresp_err   = err_q;
  assign tcp_txd     = txd_q;
  assign tcp_tx_wr   = tx_wr_q;
endmodule
